// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the CPU front end.
// Contents: word width, PC increment, default reset PC, fetch FSM state
// encoding and a helper that forces an address onto a word boundary.
package cpu_defs_pkg;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch target is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit.
// Groups the three handshakes seen by the fetch stage:
//   imem_*     : request/ack channel to instruction memory
//   redirect_* : one-cycle branch / PC-write pulse from downstream
//   inst_*     : valid/ready channel towards decode
// Modports: master = fetch unit, slave = memory/decode environment.
interface instruction_fetch_unit_if;
  import cpu_defs_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_addr;

  logic              inst_valid;
  logic [WORD_W-1:0] inst_out;
  logic [WORD_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_addr, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_addr, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   push, wdata    : write one entry (ignored when full)
//   pop            : retire the head entry (ignored when empty)
//   flush          : empty the FIFO; takes priority over push/pop
//   rdata          : head entry, read from the storage registers
//   full, empty, count : occupancy status
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [63:0]                wdata,
  output logic [63:0]                rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (count_q == {CW{1'b0}});
  assign full      = (count_q == DEPTH_C);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'd0;
      end
    end else if (flush) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one word request at a
// time to instruction memory, buffers returned words with their PCs in a
// prefetch FIFO and hands them to decode. Redirects flush the FIFO; a
// request already in flight is completed and its data thrown away.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : imem req/ack, redirect pulse and decode valid/ready
//   fifo_count     : FIFO occupancy (debug / verification)
module instruction_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset_n,
  instruction_fetch_unit_if.master  bus,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  fetch_state_e      state_q;
  logic [WORD_W-1:0] fetch_pc_q;
  logic [WORD_W-1:0] target_q;
  logic              req_q;

  logic              ack_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     next_count_d;
  logic [63:0]       head_s;
  logic [WORD_W-1:0] redirect_pc_s;

  // An ack only counts while a request is actually outstanding.
  assign ack_s         = req_q && bus.imem_ack;
  // Data returned in a redirect cycle or while discarding is stale.
  assign push_s        = (state_q == FETCH) && ack_s && !bus.redirect_valid && !full_s;
  assign pop_s         = !empty_s && bus.inst_ready;
  assign redirect_pc_s = align_word(bus.redirect_addr);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (bus.redirect_valid),
    .wdata   ({fetch_pc_q, bus.imem_rdata}),
    .rdata   (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  // Occupancy after this edge; drives the registered request qualification.
  always_comb begin
    next_count_d = count_s;
    if (bus.redirect_valid) begin
      next_count_d = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   next_count_d = count_s + ONE_C;
        2'b01:   next_count_d = count_s - ONE_C;
        default: next_count_d = count_s;
      endcase
    end
  end

  // Fetch FSM, PC and request register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      // Counting the push in flight keeps a full FIFO from ever being
      // requested into. While discarding the FIFO is empty, so req holds.
      req_q <= (next_count_d < DEPTH_C);
      case (state_q)
        FETCH: begin
          if (bus.redirect_valid) begin
            if (req_q && !bus.imem_ack) begin
              // Request still in flight: finish it before moving the PC.
              state_q  <= DISCARD;
              target_q <= redirect_pc_s;
            end else begin
              fetch_pc_q <= redirect_pc_s;
            end
          end else if (ack_s) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
          end else begin
            fetch_pc_q <= fetch_pc_q;
          end
        end
        DISCARD: begin
          if (ack_s) begin
            state_q    <= FETCH;
            fetch_pc_q <= bus.redirect_valid ? redirect_pc_s : target_q;
          end else if (bus.redirect_valid) begin
            target_q <= redirect_pc_s;
          end else begin
            target_q <= target_q;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = !empty_s;
  assign bus.inst_pc    = head_s[63:32];
  assign bus.inst_out   = head_s[31:0];
  assign fifo_count     = count_s;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (DEPTH = 4, RESET_PC = 0).
// Memory model returns addr ^ 32'hE000_0000 after mem_lat wait cycles.
module tb_instruction_fetch_unit;

  localparam logic [31:0] XMASK = 32'hE000_0000;

  logic       clk;
  logic       rst_n;
  logic [2:0] fifo_count;
  int         n_checks;
  int         n_errors;
  int         mem_lat;
  int         wait_cnt;
  int         ack_cnt;
  int         ack_base;
  logic [31:0] exp_pc;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .bus        (bus.master),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: decides the ack for the coming rising edge.
  always @(negedge clk) begin
    if (bus.imem_req) begin
      if (wait_cnt >= mem_lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = bus.imem_addr ^ XMASK;
        wait_cnt       = 0;
        ack_cnt        = ack_cnt + 1;
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt     = wait_cnt + 1;
      end
    end else begin
      bus.imem_ack = 1'b0;
      wait_cnt     = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] addr);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = addr;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.inst_valid; i++) @(negedge clk);
    chk(tag, 32'(bus.inst_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem_lat  = 0;
    wait_cnt = 0;
    ack_cnt  = 0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 32'h0;
    bus.inst_ready     = 1'b1;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(bus.imem_req),   32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_count", 32'(fifo_count),     32'd0);
    chk("rst_addr",  bus.imem_addr,       32'h0);

    // Zero-wait memory, decode always ready: one instruction per cycle
    rst_n = 1'b1;
    @(negedge clk);
    chk("s1_req",   32'(bus.imem_req),   32'd1);
    chk("s1_addr",  bus.imem_addr,       32'h0);
    chk("s1_valid0", 32'(bus.inst_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_pc = 32'(k) * 32'd4;
      chk("s1_valid", 32'(bus.inst_valid), 32'd1);
      chk("s1_pc",    bus.inst_pc,         exp_pc);
      chk("s1_inst",  bus.inst_out,        exp_pc ^ XMASK);
    end

    // Decode stalled: exactly DEPTH acks, then request drops
    bus.inst_ready = 1'b0;
    do_reset();
    ack_base = ack_cnt;
    repeat (9) @(negedge clk);
    chk("s2_acks",  32'(ack_cnt - ack_base), 32'd4);
    chk("s2_req",   32'(bus.imem_req),       32'd0);
    chk("s2_count", 32'(fifo_count),         32'd4);
    chk("s2_hold_pc",   bus.inst_pc,  32'h0);
    chk("s2_hold_inst", bus.inst_out, XMASK);
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_pc = 32'(k) * 32'd4;
      chk("s2_valid", 32'(bus.inst_valid), 32'd1);
      chk("s2_pc",    bus.inst_pc,         exp_pc);
      @(negedge clk);
    end

    // 3-cycle memory, redirect during the first wait cycle
    mem_lat = 3;
    do_reset();
    @(negedge clk);
    pulse_redirect(32'h0000_0103);
    chk("s3_req_held",  32'(bus.imem_req), 32'd1);
    chk("s3_addr_held", bus.imem_addr,     32'h0);
    chk("s3_flushed",   32'(bus.inst_valid), 32'd0);
    for (int i = 0; i < 10 && bus.imem_addr == 32'h0; i++) @(negedge clk);
    chk("s3_new_addr",  bus.imem_addr,     32'h0000_0100);
    chk("s3_new_req",   32'(bus.imem_req), 32'd1);
    chk("s3_no_stale",  32'(bus.inst_valid), 32'd0);
    wait_valid("s3_valid", 20);
    chk("s3_pc",   bus.inst_pc,  32'h0000_0100);
    chk("s3_inst", bus.inst_out, 32'h0000_0100 ^ XMASK);

    // Redirect coincident with an ack and a pop
    mem_lat = 0;
    do_reset();
    repeat (3) @(negedge clk);
    chk("s4_head_before", bus.inst_pc, 32'h4);
    pulse_redirect(32'h0000_0200);
    chk("s4_count", 32'(fifo_count),     32'd0);
    chk("s4_valid", 32'(bus.inst_valid), 32'd0);
    chk("s4_addr",  bus.imem_addr,       32'h0000_0200);
    chk("s4_req",   32'(bus.imem_req),   32'd1);
    @(negedge clk);
    chk("s4_pc",   bus.inst_pc,  32'h0000_0200);
    chk("s4_inst", bus.inst_out, 32'h0000_0200 ^ XMASK);

    // PC wrap past the top of the address space; low bits of target ignored
    do_reset();
    repeat (2) @(negedge clk);
    pulse_redirect(32'hFFFF_FFFB);
    wait_valid("s5_valid", 10);
    chk("s5_pc0", bus.inst_pc,  32'hFFFF_FFF8);
    chk("s5_in0", bus.inst_out, 32'hFFFF_FFF8 ^ XMASK);
    @(negedge clk);
    chk("s5_pc1", bus.inst_pc,  32'hFFFF_FFFC);
    @(negedge clk);
    chk("s5_pc2", bus.inst_pc,  32'h0000_0000);
    chk("s5_in2", bus.inst_out, XMASK);

    // Asynchronous reset with a pending request and two buffered entries
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    chk("s6_pre_count", 32'(fifo_count),   32'd2);
    chk("s6_pre_req",   32'(bus.imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s6_req",   32'(bus.imem_req),   32'd0);
    chk("s6_valid", 32'(bus.inst_valid), 32'd0);
    chk("s6_count", 32'(fifo_count),     32'd0);
    repeat (2) @(negedge clk);
    bus.inst_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_restart_addr", bus.imem_addr,     32'h0);
    chk("s6_restart_req",  32'(bus.imem_req), 32'd1);
    wait_valid("s6_valid_after", 10);
    chk("s6_restart_pc", bus.inst_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
